sprite_palette_bank: RTL and testbench

- Writable, multi-bank colour palette with registered lookup. It replaces the fixed per-sprite 256x12 palette ROMs with one shared block holding NUM_BANKS palettes, for example one bank per fruit sprite.
- Sits between the sprite ROM index output and the VGA colour mux.
- Adds three capabilities:
  - transparent-index detection,
  - a runtime palette write port,
  - a frame-timed fade-out FSM, used when a sliced fruit disappears.

---
 rtl/sprite_palette_bank_if.sv | 65 ++++++
 rtl/sprite_palette_bank.sv | 166 ++++++++++++++++
 tb/tb_sprite_palette_bank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_palette_bank_if.sv
// sprite_palette_bank_if
//   Bundles the pixel lookup, palette write and fade control signals of
//   sprite_palette_bank.
//   slave  : palette side (lookup/write/fade requests in, colour and flags out)
//   master : requester side
//   With PALETTE_READBACK_EN defined, the rd_req/rd_bank/rd_index/rd_ack/rd_data
//   readback channel is added.
interface sprite_palette_bank_if #(
  parameter int NUM_BANKS = 4,
  parameter int INDEX_W   = 8,
  parameter int CH_W      = 4
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                pix_valid;
  logic [BANK_W-1:0]   pix_bank;
  logic [INDEX_W-1:0]  pix_index;
  logic                out_valid;
  logic [CH_W-1:0]     red;
  logic [CH_W-1:0]     green;
  logic [CH_W-1:0]     blue;
  logic                out_opaque;
  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [INDEX_W-1:0]  wr_index;
  logic [3*CH_W-1:0]   wr_data;
  logic                frame_tick;
  logic                fade_start;
  logic                fade_clear;
  logic                fade_busy;
  logic                fade_done;
`ifdef PALETTE_READBACK_EN
  logic                rd_req;
  logic [BANK_W-1:0]   rd_bank;
  logic [INDEX_W-1:0]  rd_index;
  logic                rd_ack;
  logic [3*CH_W-1:0]   rd_data;
`endif

  modport slave (
    input  pix_valid, pix_bank, pix_index,
    input  wr_en, wr_bank, wr_index, wr_data,
    input  frame_tick, fade_start, fade_clear,
    output out_valid, red, green, blue, out_opaque,
    output fade_busy, fade_done
`ifdef PALETTE_READBACK_EN
    ,
    input  rd_req, rd_bank, rd_index,
    output rd_ack, rd_data
`endif
  );

  modport master (
    output pix_valid, pix_bank, pix_index,
    output wr_en, wr_bank, wr_index, wr_data,
    output frame_tick, fade_start, fade_clear,
    input  out_valid, red, green, blue, out_opaque,
    input  fade_busy, fade_done
`ifdef PALETTE_READBACK_EN
    ,
    output rd_req, rd_bank, rd_index,
    input  rd_ack, rd_data
`endif
  );
endinterface

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank
//   Shared, writable multi-bank colour palette with a 2-stage registered
//   lookup, transparent-index flag and a frame-timed fade-out FSM.
//   Ports:
//     Clk      : pixel clock
//     Reset_n  : asynchronous active-low reset
//     bus      : sprite_palette_bank_if.slave (lookup, write, fade control,
//                colour out, fade flags)
//   Optional: define PALETTE_READBACK_EN to add a one-cycle readback channel
//   (rd_req/rd_bank/rd_index -> rd_ack/rd_data) on the interface.
module sprite_palette_bank #(
  parameter int NUM_BANKS       = 4,
  parameter int INDEX_W         = 8,
  parameter int CH_W            = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FADE_FRAMES     = 2
) (
  input logic                Clk,
  input logic                Reset_n,
  sprite_palette_bank_if.slave bus
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ADDR_W = BANK_W + INDEX_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RGB_W  = 3 * CH_W;
  localparam int PROD_W = 2 * CH_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FADING = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [7:0]         TICK_LAST = 8'(FADE_FRAMES - 1);
  localparam logic [INDEX_W-1:0] TRANSP    = INDEX_W'(TRANSPARENT_IDX);

  logic [RGB_W-1:0]  r_mem [DEPTH];
  logic [RGB_W-1:0]  r_s1_rgb;
  logic              r_s1_opq;
  logic [1:0]        r_vld_pipe;   // [0] stage 1, [1] stage 2
  logic [CH_W-1:0]   r_red, r_green, r_blue;
  logic              r_opq;
  logic [1:0]        r_state;
  logic [3:0]        r_level;
  logic [7:0]        r_tick;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_pix_addr = {bus.pix_bank, bus.pix_index};
  assign w_wr_addr  = {bus.wr_bank, bus.wr_index};

  function automatic logic [CH_W-1:0] f_scale(input logic [CH_W-1:0] c,
                                              input logic [1:0] st,
                                              input logic [3:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lvl);
    case (st)
      ST_IDLE:   return c;
      ST_FADING: return prod[PROD_W-1:CH_W];
      default:   return '0;
    endcase
  endfunction

  // Storage is deliberately not reset so it maps onto block RAM. The read
  // sees the pre-write contents when the write hits the same entry.
  always_ff @(posedge Clk) begin
    if (bus.wr_en) r_mem[w_wr_addr] <= bus.wr_data;
    r_s1_rgb <= r_mem[w_pix_addr];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vld_pipe <= '0;
      r_s1_opq   <= 1'b0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
      r_opq      <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], bus.pix_valid};
      r_s1_opq   <= (bus.pix_index != TRANSP);
      // Fade level is sampled here, one cycle after the lookup was issued.
      if (r_vld_pipe[0]) begin
        r_red   <= f_scale(r_s1_rgb[3*CH_W-1:2*CH_W], r_state, r_level);
        r_green <= f_scale(r_s1_rgb[2*CH_W-1:CH_W],   r_state, r_level);
        r_blue  <= f_scale(r_s1_rgb[CH_W-1:0],        r_state, r_level);
        r_opq   <= r_s1_opq;
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
        r_opq   <= 1'b0;
      end
    end
  end

  // Fade FSM: fade_clear beats both fade_start and the level step.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_level <= 4'hF;
      r_tick  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.fade_start && !bus.fade_clear) begin
            r_state <= ST_FADING;
            r_level <= 4'hF;
            r_tick  <= '0;
          end
        end
        ST_FADING: begin
          if (bus.fade_clear) begin
            r_state <= ST_IDLE;
            r_level <= 4'hF;
            r_tick  <= '0;
          end else if (bus.frame_tick) begin
            if (r_tick == TICK_LAST) begin
              r_tick  <= '0;
              r_level <= r_level - 4'd1;
              if (r_level == 4'd1) r_state <= ST_DONE;
            end else begin
              r_tick <= r_tick + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (bus.fade_clear) begin
            r_state <= ST_IDLE;
            r_level <= 4'hF;
            r_tick  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid  = r_vld_pipe[1];
  assign bus.red        = r_red;
  assign bus.green      = r_green;
  assign bus.blue       = r_blue;
  assign bus.out_opaque = r_opq;
  assign bus.fade_busy  = (r_state == ST_FADING);
  assign bus.fade_done  = (r_state == ST_DONE);

`ifdef PALETTE_READBACK_EN
  logic              r_rd_ack;
  logic [RGB_W-1:0]  r_rd_data;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_rd_addr = {bus.rd_bank, bus.rd_index};

  // Separate read port, so readback never competes with pixel lookups.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_sprite_palette_bank.sv
module tb_sprite_palette_bank;
  localparam int NB = 4, IW = 8, CW = 4, FF = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sprite_palette_bank_if #(.NUM_BANKS(NB), .INDEX_W(IW), .CH_W(CW)) bus();

  sprite_palette_bank #(
    .NUM_BANKS(NB), .INDEX_W(IW), .CH_W(CW),
    .TRANSPARENT_IDX(0), .FADE_FRAMES(FF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_mem [NB*256];
  int m_state = 0;             // 0 idle, 1 fading, 2 done
  int m_level = 15, m_ticks = 0, cyc = 0;
  int h_state [int];
  int h_level [int];
  typedef struct { logic [11:0] raw; bit opq; int issue; } exp_t;
  exp_t sb[$];

  function automatic int scale(input int c, input int st, input int lv);
    if (st == 0) return c;
    if (st == 2) return 0;
    return (c * lv) / 16;
  endfunction

  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      m_state = 0; m_level = 15; m_ticks = 0;
      sb.delete();
    end else begin
      h_state[cyc] = m_state;
      h_level[cyc] = m_level;
      if (bus.pix_valid)
        sb.push_back('{m_mem[{bus.pix_bank, bus.pix_index}], (bus.pix_index != 0), cyc});
      if (bus.wr_en) m_mem[{bus.wr_bank, bus.wr_index}] = bus.wr_data;
      case (m_state)
        0: if (!bus.fade_clear && bus.fade_start) begin
             m_state = 1; m_level = 15; m_ticks = 0;
           end
        1: if (bus.fade_clear) begin
             m_state = 0; m_level = 15;
           end else if (bus.frame_tick) begin
             m_ticks++;
             if (m_ticks == FF) begin
               m_ticks = 0; m_level--;
               if (m_level == 0) m_state = 2;
             end
           end
        default: if (bus.fade_clear) begin m_state = 0; m_level = 15; end
      endcase
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    exp_t e;
    int st, lv, er;
    @(negedge Clk);
    if (Reset_n) begin
      check("fade_busy", 32'(bus.fade_busy), 32'(m_state == 1));
      check("fade_done", 32'(bus.fade_done), 32'(m_state == 2));
      if (sb.size() > 0 && sb[0].issue + 2 == cyc) begin
        e  = sb.pop_front();
        st = h_state[e.issue + 1];
        lv = h_level[e.issue + 1];
        er = (scale(int'(e.raw[11:8]), st, lv) << 8) | (scale(int'(e.raw[7:4]), st, lv) << 4)
             | scale(int'(e.raw[3:0]), st, lv);
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(er));
        check("out_opaque", 32'(bus.out_opaque), 32'(e.opq));
      end else begin
        check("out_valid_idle", 32'(bus.out_valid), 32'd0);
        check("rgb_idle", 32'({bus.red, bus.green, bus.blue}), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic clr();
    bus.pix_valid = 0; bus.pix_bank = 0; bus.pix_index = 0;
    bus.wr_en = 0; bus.wr_bank = 0; bus.wr_index = 0; bus.wr_data = 0;
    bus.frame_tick = 0; bus.fade_start = 0; bus.fade_clear = 0;
`ifdef PALETTE_READBACK_EN
    bus.rd_req = 0; bus.rd_bank = 0; bus.rd_index = 0;
`endif
  endtask

  task automatic wr(input int b, input int i, input logic [11:0] d);
    bus.wr_en = 1; bus.wr_bank = 2'(b); bus.wr_index = 8'(i); bus.wr_data = d;
    step(); bus.wr_en = 0;
  endtask

  task automatic look(input int b, input int i);
    bus.pix_valid = 1; bus.pix_bank = 2'(b); bus.pix_index = 8'(i);
    step(); bus.pix_valid = 0;
  endtask

  task automatic tick_pulse();
    bus.frame_tick = 1; step(); bus.frame_tick = 0; step();
  endtask

  task automatic rgb_is(input string name, input logic [11:0] exp);
    check(name, 32'({bus.red, bus.green, bus.blue}), 32'(exp));
  endtask

  initial begin
    clr();
    Reset_n = 0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rgb_is("rst_rgb", 12'h000);
    check("rst_busy", 32'(bus.fade_busy), 32'd0);
    check("rst_done", 32'(bus.fade_done), 32'd0);
    Reset_n = 1;
    step();

    // fill every entry so later random lookups never see undefined data
    for (int a = 0; a < NB*256; a++) wr(a / 256, a % 256, 12'($urandom));

    // basic write then lookup
    wr(1, 5, 12'hE73);
    look(1, 5); step();
    check("lk_valid", 32'(bus.out_valid), 32'd1);
    rgb_is("lk_rgb", 12'hE73);
    check("lk_opaque", 32'(bus.out_opaque), 32'd1);
    look(1, 0); step();
    check("transp_opaque", 32'(bus.out_opaque), 32'd0);

    // back-to-back writes to one entry: last wins
    wr(2, 7, 12'h111); wr(2, 7, 12'h222);
    look(2, 7); step();
    rgb_is("last_write_wins", 12'h222);

    // read-first collision
    wr(0, 3, 12'h123);
    bus.wr_en = 1; bus.wr_bank = 0; bus.wr_index = 3; bus.wr_data = 12'h9A2;
    bus.pix_valid = 1; bus.pix_bank = 0; bus.pix_index = 3;
    step();
    bus.wr_en = 0;
    look(0, 3);
    rgb_is("collision_old", 12'h123);
    step();
    rgb_is("collision_new", 12'h9A2);

    // fade-out
    bus.fade_start = 1; step(); bus.fade_start = 0;
    check("fade_busy_on", 32'(bus.fade_busy), 32'd1);
    repeat (2) tick_pulse();
    look(1, 5); step();
    rgb_is("fade_lvl14", 12'hC62);
    repeat (28) tick_pulse();
    check("fade_done_30", 32'(bus.fade_done), 32'd1);
    look(1, 5); step();
    rgb_is("done_black", 12'h000);

    // fade_clear with a coincident tick
    bus.fade_clear = 1; step(); bus.fade_clear = 0;
    bus.fade_start = 1; step(); bus.fade_start = 0;
    repeat (3) tick_pulse();
    bus.fade_clear = 1; bus.frame_tick = 1; step();
    bus.fade_clear = 0; bus.frame_tick = 0;
    check("clear_busy", 32'(bus.fade_busy), 32'd0);
    check("clear_done", 32'(bus.fade_done), 32'd0);
    look(1, 5); step();
    rgb_is("clear_rgb", 12'hE73);

    // asynchronous reset mid-fade with lookups in flight
    bus.fade_start = 1; step(); bus.fade_start = 0;
    repeat (2) tick_pulse();
    look(1, 5);
    bus.pix_valid = 1; bus.pix_bank = 1; bus.pix_index = 5;
    step();
    bus.pix_valid = 0;
    Reset_n = 0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    rgb_is("arst_rgb", 12'h000);
    check("arst_busy", 32'(bus.fade_busy), 32'd0);
    check("arst_done", 32'(bus.fade_done), 32'd0);
    step(); step();
    Reset_n = 1;
    step();
    check("post_rst_busy", 32'(bus.fade_busy), 32'd0);
    look(1, 5); step();
    rgb_is("post_rst_rgb", 12'hE73);

`ifdef PALETTE_READBACK_EN
    bus.rd_req = 1; bus.rd_bank = 1; bus.rd_index = 5;
    bus.pix_valid = 1; bus.pix_bank = 2; bus.pix_index = 7;
    step();
    check("rd_ack_1", 32'(bus.rd_ack), 32'd1);
    check("rd_data_1", 32'(bus.rd_data), 32'h0E73);
    step();
    bus.rd_req = 0; bus.pix_valid = 0;
    check("rd_ack_2", 32'(bus.rd_ack), 32'd1);
    check("rd_data_2", 32'(bus.rd_data), 32'h0E73);
    step();
    check("rd_ack_off", 32'(bus.rd_ack), 32'd0);
    check("rd_data_hold", 32'(bus.rd_data), 32'h0E73);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      bus.pix_valid  = ($urandom_range(0, 9) < 7);
      bus.pix_bank   = 2'($urandom);
      bus.pix_index  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      bus.wr_en      = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_bank = bus.pix_bank; bus.wr_index = bus.pix_index;
      end else begin
        bus.wr_bank = 2'($urandom); bus.wr_index = 8'($urandom);
      end
      bus.wr_data    = 12'($urandom);
      bus.frame_tick = ($urandom_range(0, 4) == 0);
      bus.fade_start = ($urandom_range(0, 19) == 0);
      bus.fade_clear = ($urandom_range(0, 199) == 0);
      step();
    end
    clr();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
